// File: rtl/mem_shim.sv
// Request-FIFO to Avalon-MM DDR3 bridge: one outstanding command, 1-entry skid for late beats.
// Optional MEM_SHIM_RESP_REG_EN registers the read-response path (1 cycle); default is passthrough.
module mem_shim (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mem_req_rd_cmd,
  input  logic [21:0] mem_req_rd_addr,
  input  logic [63:0] mem_req_rd_dta,
  output logic        mem_req_rd_en,
  input  logic        mem_req_rd_valid,
  output logic [63:0] mem_res_wr_dta,
  output logic        mem_res_wr_en,
  input  logic        mem_res_wr_almost_full,
  output logic [28:0] ddr3_addr,
  output logic [7:0]  ddr3_burstcnt,
  output logic        ddr3_read,
  output logic        ddr3_write,
  output logic [63:0] ddr3_writedata,
  output logic [7:0]  ddr3_byteenable,
  input  logic [63:0] ddr3_readdata,
  input  logic        ddr3_readdatavalid,
  input  logic        ddr3_waitrequest
);

  localparam int DATA_W = 64;
  localparam int ADDR_W = 22;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_nxt;

  logic              saved_valid;
  logic [1:0]        skid_cmd_p1;
  logic [ADDR_W-1:0] skid_addr_p1;
  logic [DATA_W-1:0] skid_dta_p1;

  logic [1:0]        sel_cmd_p0;
  logic [ADDR_W-1:0] sel_addr_p0;
  logic [DATA_W-1:0] sel_dta_p0;
  logic              issue_skid, issue_beat, issue_cmd;
  logic              skid_cap, skid_drop;

  // Word address to DDR3 byte-pair address inside the 0x6 region.
  function automatic logic [28:0] map_addr(input logic [ADDR_W-1:0] a);
    return {4'b0110, 2'b00, a, 1'b0};
  endfunction

  assign ddr3_burstcnt   = 8'd1;
  assign ddr3_byteenable = 8'hFF;

  assign mem_req_rd_en = rst_n && (state == IDLE) && !saved_valid && !mem_res_wr_almost_full;

  // Stage p0: pick the skid entry ahead of the live beat
  always_comb begin
    sel_cmd_p0  = mem_req_rd_cmd;
    sel_addr_p0 = mem_req_rd_addr;
    sel_dta_p0  = mem_req_rd_dta;
    if (saved_valid) begin
      sel_cmd_p0  = skid_cmd_p1;
      sel_addr_p0 = skid_addr_p1;
      sel_dta_p0  = skid_dta_p1;
    end
  end

  always_comb begin
    state_nxt  = state;
    issue_skid = 1'b0;
    issue_beat = 1'b0;
    case (state)
      IDLE: begin
        issue_skid = saved_valid;
        issue_beat = !saved_valid && mem_req_rd_valid;
        if ((issue_skid || issue_beat) && sel_cmd_p0[1]) state_nxt = WAIT;
      end
      WAIT: begin
        if (!ddr3_waitrequest) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign issue_cmd = (issue_skid || issue_beat) && sel_cmd_p0[1];
  assign skid_cap  = mem_req_rd_valid && ((state != IDLE) || issue_skid);
  assign skid_drop = skid_cap && saved_valid && !issue_skid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stage p1: Avalon command registers, held until waitrequest drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ddr3_read      <= 1'b0;
      ddr3_write     <= 1'b0;
      ddr3_addr      <= '0;
      ddr3_writedata <= '0;
    end else if (issue_cmd) begin
      ddr3_read      <= !sel_cmd_p0[0];
      ddr3_write     <= sel_cmd_p0[0];
      ddr3_addr      <= map_addr(sel_addr_p0);
      ddr3_writedata <= sel_dta_p0;
    end else if ((state == WAIT) && !ddr3_waitrequest) begin
      ddr3_read  <= 1'b0;
      ddr3_write <= 1'b0;
    end
  end

  // Stage p1: skid entry for a beat that lands while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saved_valid  <= 1'b0;
      skid_cmd_p1  <= '0;
      skid_addr_p1 <= '0;
      skid_dta_p1  <= '0;
    end else if (skid_cap && !skid_drop) begin
      saved_valid  <= 1'b1;
      skid_cmd_p1  <= mem_req_rd_cmd;
      skid_addr_p1 <= mem_req_rd_addr;
      skid_dta_p1  <= mem_req_rd_dta;
    end else if (issue_skid) begin
      saved_valid <= 1'b0;
    end
  end

`ifdef MEM_SHIM_RESP_REG_EN
  logic              res_vld_p1;
  logic [DATA_W-1:0] res_dta_p1;

  // Stage p1: registered response path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld_p1 <= 1'b0;
      res_dta_p1 <= '0;
    end else begin
      res_vld_p1 <= ddr3_readdatavalid;
      if (ddr3_readdatavalid) res_dta_p1 <= ddr3_readdata;
    end
  end

  assign mem_res_wr_en  = res_vld_p1;
  assign mem_res_wr_dta = res_dta_p1;
`else
  assign mem_res_wr_en  = rst_n && ddr3_readdatavalid;
  assign mem_res_wr_dta = rst_n ? ddr3_readdata : '0;
`endif

  a_skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !skid_drop)
    else $error("mem_shim: request beat dropped, skid register already full");

  a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(ddr3_read && ddr3_write))
    else $error("mem_shim: ddr3_read and ddr3_write asserted together");

endmodule

// File: tb/tb_mem_shim.sv
// Self-checking bench for mem_shim: vector table, directed corner sequences, random run vs model.
module tb_mem_shim;

`ifdef MEM_SHIM_RESP_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mem_req_rd_cmd;
  logic [21:0] mem_req_rd_addr;
  logic [63:0] mem_req_rd_dta;
  logic        mem_req_rd_en;
  logic        mem_req_rd_valid;
  logic [63:0] mem_res_wr_dta;
  logic        mem_res_wr_en;
  logic        mem_res_wr_almost_full;
  logic [28:0] ddr3_addr;
  logic [7:0]  ddr3_burstcnt;
  logic        ddr3_read;
  logic        ddr3_write;
  logic [63:0] ddr3_writedata;
  logic [7:0]  ddr3_byteenable;
  logic [63:0] ddr3_readdata;
  logic        ddr3_readdatavalid;
  logic        ddr3_waitrequest;

  always #5 clk = ~clk;

  mem_shim dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .mem_req_rd_cmd         (mem_req_rd_cmd),
    .mem_req_rd_addr        (mem_req_rd_addr),
    .mem_req_rd_dta         (mem_req_rd_dta),
    .mem_req_rd_en          (mem_req_rd_en),
    .mem_req_rd_valid       (mem_req_rd_valid),
    .mem_res_wr_dta         (mem_res_wr_dta),
    .mem_res_wr_en          (mem_res_wr_en),
    .mem_res_wr_almost_full (mem_res_wr_almost_full),
    .ddr3_addr              (ddr3_addr),
    .ddr3_burstcnt          (ddr3_burstcnt),
    .ddr3_read              (ddr3_read),
    .ddr3_write             (ddr3_write),
    .ddr3_writedata         (ddr3_writedata),
    .ddr3_byteenable        (ddr3_byteenable),
    .ddr3_readdata          (ddr3_readdata),
    .ddr3_readdatavalid     (ddr3_readdatavalid),
    .ddr3_waitrequest       (ddr3_waitrequest)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic beat(input logic [1:0] c, input logic [21:0] a, input logic [63:0] d);
    mem_req_rd_valid = 1'b1;
    mem_req_rd_cmd   = c;
    mem_req_rd_addr  = a;
    mem_req_rd_dta   = d;
  endtask

  // DDR3 address as the spec defines it: region 0x6 at bit 25, word address doubled.
  function automatic logic [28:0] ref_addr(input logic [21:0] a);
    return 29'h0C00_0000 + {7'd0, a} * 29'd2;
  endfunction

  typedef struct {
    logic [1:0]  cmd;
    logic [21:0] addr;
    logic [63:0] dta;
    logic        exp_rd;
    logic        exp_wr;
    logic [28:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [1:0]  cmd;
    logic [21:0] addr;
    logic [63:0] dta;
  } req_t;

  vec_t vecs[6];
  req_t exp_q[$];

  logic        hold_v;
  logic        hold_rd, hold_wr;
  logic [28:0] hold_addr;
  logic [63:0] hold_wd;
  logic        rdv_prev;
  logic [63:0] rdd_prev;
  logic        rd_en_s;

  task automatic monitor();
    req_t  r;
    logic        exp_en;
    logic [63:0] exp_d;
    chk("rw_exclusive", 64'(ddr3_read & ddr3_write), 64'd0);
    if (hold_v) begin
      chk("hold_cmd", 64'({ddr3_read, ddr3_write}), 64'({hold_rd, hold_wr}));
      chk("hold_addr", 64'(ddr3_addr), 64'(hold_addr));
      chk("hold_wdata", ddr3_writedata, hold_wd);
    end
    hold_v    = (ddr3_read || ddr3_write) && ddr3_waitrequest;
    hold_rd   = ddr3_read;
    hold_wr   = ddr3_write;
    hold_addr = ddr3_addr;
    hold_wd   = ddr3_writedata;
    if ((ddr3_read || ddr3_write) && !ddr3_waitrequest) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", 64'({ddr3_read, ddr3_write}), 64'd0);
      end else begin
        r = exp_q.pop_front();
        chk("acc_read", 64'(ddr3_read), 64'(r.cmd == 2'd2));
        chk("acc_write", 64'(ddr3_write), 64'(r.cmd == 2'd3));
        chk("acc_addr", 64'(ddr3_addr), 64'(ref_addr(r.addr)));
        if (r.cmd == 2'd3) chk("acc_wdata", ddr3_writedata, r.dta);
      end
    end
    exp_en = (LAT == 0) ? ddr3_readdatavalid : rdv_prev;
    exp_d  = (LAT == 0) ? ddr3_readdata : rdd_prev;
    chk("res_en", 64'(mem_res_wr_en), 64'(exp_en));
    if (exp_en) chk("res_dta", mem_res_wr_dta, exp_d);
    rdv_prev = ddr3_readdatavalid;
    rdd_prev = ddr3_readdata;
  endtask

  initial begin
    req_t r;
    vecs[0] = '{2'd3, 22'h123456, 64'hDEADBEEFCAFEBABE, 1'b0, 1'b1, 29'h0C2468AC};
    vecs[1] = '{2'd2, 22'h1BCDEF, 64'h0,                1'b1, 1'b0, 29'h0C379BDE};
    vecs[2] = '{2'd0, 22'h000001, 64'h1111,             1'b0, 1'b0, 29'h0};
    vecs[3] = '{2'd3, 22'h3FFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 29'h0C7FFFFE};
    vecs[4] = '{2'd1, 22'h2AAAAA, 64'h2222,             1'b0, 1'b0, 29'h0};
    vecs[5] = '{2'd2, 22'h000000, 64'h0,                1'b1, 1'b0, 29'h0C000000};

    rst_n = 1'b0;
    mem_req_rd_valid = 1'b0;
    mem_req_rd_cmd = 2'd0;
    mem_req_rd_addr = '0;
    mem_req_rd_dta = '0;
    mem_res_wr_almost_full = 1'b0;
    ddr3_waitrequest = 1'b0;
    ddr3_readdatavalid = 1'b1;
    ddr3_readdata = 64'hA5A5A5A5A5A5A5A5;

    // reset state, with a response beat presented that must not leak through
    repeat (3) cyc();
    smp();
    chk("rst_rd_en", 64'(mem_req_rd_en), 64'd0);
    chk("rst_read", 64'(ddr3_read), 64'd0);
    chk("rst_write", 64'(ddr3_write), 64'd0);
    chk("rst_addr", 64'(ddr3_addr), 64'd0);
    chk("rst_wdata", ddr3_writedata, 64'd0);
    chk("rst_res_en", 64'(mem_res_wr_en), 64'd0);
    chk("rst_res_dta", mem_res_wr_dta, 64'd0);
    chk("rst_burstcnt", 64'(ddr3_burstcnt), 64'd1);
    chk("rst_byteen", 64'(ddr3_byteenable), 64'hFF);
    cyc();
    rst_n = 1'b1;
    ddr3_readdatavalid = 1'b0;
    smp();
    chk("post_rst_rd_en", 64'(mem_req_rd_en), 64'd1);

    // vector table: one beat, check the issued command, then the return to idle
    for (int i = 0; i < 6; i++) begin
      cyc();
      beat(vecs[i].cmd, vecs[i].addr, vecs[i].dta);
      cyc();
      mem_req_rd_valid = 1'b0;
      smp();
      chk($sformatf("v%0d_read", i), 64'(ddr3_read), 64'(vecs[i].exp_rd));
      chk($sformatf("v%0d_write", i), 64'(ddr3_write), 64'(vecs[i].exp_wr));
      chk($sformatf("v%0d_rd_en", i), 64'(mem_req_rd_en), 64'(!(vecs[i].exp_rd || vecs[i].exp_wr)));
      if (vecs[i].exp_rd || vecs[i].exp_wr)
        chk($sformatf("v%0d_addr", i), 64'(ddr3_addr), 64'(vecs[i].exp_addr));
      if (vecs[i].exp_wr)
        chk($sformatf("v%0d_wdata", i), ddr3_writedata, vecs[i].dta);
      cyc();
      smp();
      chk($sformatf("v%0d_idle_rw", i), 64'({ddr3_read, ddr3_write}), 64'd0);
      chk($sformatf("v%0d_idle_rd_en", i), 64'(mem_req_rd_en), 64'd1);
    end

    // read with response through the response port
    cyc();
    beat(2'd2, 22'h1BCDEF, 64'h0);
    cyc();
    mem_req_rd_valid = 1'b0;
    smp();
    chk("resp_read", 64'(ddr3_read), 64'd1);
    chk("resp_addr", 64'(ddr3_addr), 64'h0C379BDE);
    cyc();
    ddr3_readdatavalid = 1'b1;
    ddr3_readdata = 64'h0123456789ABCDEF;
    for (int k = 0; k < 2; k++) begin
      smp();
      chk($sformatf("resp_en_c%0d", k), 64'(mem_res_wr_en), 64'(k == LAT));
      if (k == LAT) chk("resp_dta", mem_res_wr_dta, 64'h0123456789ABCDEF);
      cyc();
      ddr3_readdatavalid = 1'b0;
      ddr3_readdata = 64'hFEDCBA9876543210;
    end

    // backpressure: read held for 3 stalled cycles
    beat(2'd2, 22'h0ABCDE, 64'h0);
    ddr3_waitrequest = 1'b1;
    cyc();
    mem_req_rd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("bp_read_%0d", k), 64'(ddr3_read), 64'd1);
      chk($sformatf("bp_addr_%0d", k), 64'(ddr3_addr), 64'h0C1579BC);
      chk($sformatf("bp_rd_en_%0d", k), 64'(mem_req_rd_en), 64'd0);
      cyc();
    end
    ddr3_waitrequest = 1'b0;
    smp();
    chk("bp_read_last", 64'(ddr3_read), 64'd1);
    cyc();
    smp();
    chk("bp_released", 64'(ddr3_read), 64'd0);
    chk("bp_rd_en", 64'(mem_req_rd_en), 64'd1);

    // skid: read arrives while the write is stalled
    cyc();
    beat(2'd3, 22'h2AAAAA, 64'h5555AAAA5555AAAA);
    ddr3_waitrequest = 1'b1;
    cyc();
    beat(2'd2, 22'h155555, 64'h0);
    cyc();
    mem_req_rd_valid = 1'b0;
    smp();
    chk("skid_write", 64'(ddr3_write), 64'd1);
    chk("skid_waddr", 64'(ddr3_addr), 64'h0C555554);
    chk("skid_rd_en_wait", 64'(mem_req_rd_en), 64'd0);
    cyc();
    ddr3_waitrequest = 1'b0;
    smp();
    chk("skid_write_held", 64'(ddr3_write), 64'd1);
    cyc();
    smp();
    chk("skid_gap_rw", 64'({ddr3_read, ddr3_write}), 64'd0);
    chk("skid_gap_rd_en", 64'(mem_req_rd_en), 64'd0);
    cyc();
    smp();
    chk("skid_read", 64'(ddr3_read), 64'd1);
    chk("skid_raddr", 64'(ddr3_addr), 64'h0C2AAAAA);
    chk("skid_rd_en_issue", 64'(mem_req_rd_en), 64'd0);
    cyc();
    smp();
    chk("skid_done_read", 64'(ddr3_read), 64'd0);
    chk("skid_done_rd_en", 64'(mem_req_rd_en), 64'd1);

    // flow control: almost_full blocks pops and commands
    cyc();
    mem_res_wr_almost_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("af_rd_en_%0d", k), 64'(mem_req_rd_en), 64'd0);
      chk($sformatf("af_rw_%0d", k), 64'({ddr3_read, ddr3_write}), 64'd0);
      cyc();
    end
    mem_res_wr_almost_full = 1'b0;
    smp();
    chk("af_release_rd_en", 64'(mem_req_rd_en), 64'd1);
    cyc();
    beat(2'd0, 22'h3C3C3C, 64'h77);
    cyc();
    mem_req_rd_valid = 1'b0;
    smp();
    chk("noop_rw", 64'({ddr3_read, ddr3_write}), 64'd0);
    chk("noop_rd_en", 64'(mem_req_rd_en), 64'd1);

    // reset mid-operation abandons the command and the skid entry
    cyc();
    beat(2'd3, 22'h00ABCD, 64'h1234);
    ddr3_waitrequest = 1'b1;
    cyc();
    beat(2'd2, 22'h00DCBA, 64'h0);
    cyc();
    mem_req_rd_valid = 1'b0;
    smp();
    chk("mid_write", 64'(ddr3_write), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rw", 64'({ddr3_read, ddr3_write}), 64'd0);
    chk("mid_rst_rd_en", 64'(mem_req_rd_en), 64'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    ddr3_waitrequest = 1'b0;
    cyc();
    cyc();
    smp();
    chk("mid_after_rw", 64'({ddr3_read, ddr3_write}), 64'd0);
    chk("mid_after_rd_en", 64'(mem_req_rd_en), 64'd1);

    // random traffic against the transaction-level model
    hold_v   = 1'b0;
    rdv_prev = 1'b0;
    rdd_prev = '0;
    rd_en_s  = mem_req_rd_en;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (rd_en_s && ($urandom_range(9) < 7)) begin
        r.cmd  = 2'($urandom);
        r.addr = 22'($urandom);
        r.dta  = {$urandom, $urandom};
        beat(r.cmd, r.addr, r.dta);
        if (r.cmd >= 2'd2) exp_q.push_back(r);
      end else begin
        mem_req_rd_valid = 1'b0;
      end
      ddr3_waitrequest       = ($urandom_range(2) == 0);
      mem_res_wr_almost_full = ($urandom_range(7) == 0);
      ddr3_readdatavalid     = ($urandom_range(2) == 0);
      ddr3_readdata          = {$urandom, $urandom};
      smp();
      monitor();
      rd_en_s = mem_req_rd_en;
    end
    for (int c = 0; c < 40; c++) begin
      cyc();
      mem_req_rd_valid       = 1'b0;
      ddr3_waitrequest       = 1'b0;
      mem_res_wr_almost_full = 1'b0;
      ddr3_readdatavalid     = 1'b0;
      smp();
      monitor();
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
